apb_regfile_slv: RTL and testbench

//  Parametrised APB4 slave: register file with byte strobes and per-register read-only (RO) protection.

---
 rtl/apb_slv_pkg.sv | 20 ++
 rtl/apb_regfile_slv_if.sv | 23 ++
 rtl/apb_regfile_core.sv | 54 +++++
 rtl/apb_regfile_slv.sv | 156 +++++++++++++++
 tb/tb_apb_regfile_slv.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and helpers for the APB register-file slave.
package apb_slv_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} apb_slv_state_e;

    localparam logic APB_OKAY = 1'b0;
    localparam logic APB_ERR  = 1'b1;

    // Byte-lane merge sized for the widest bus; narrower buses zero-extend their operands.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_regfile_slv_if.sv
// APB4 completer-side signal bundle for the register-file slave.
interface apb_regfile_slv_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    localparam int NB = DATA_WIDTH / 8;

    logic                  Psel;
    logic                  Penable;
    logic                  Pwrite;
    logic [ADDR_WIDTH-1:0] Paddr;
    logic [DATA_WIDTH-1:0] Pwdata;
    logic [NB-1:0]         Pstrb;
    logic [DATA_WIDTH-1:0] Prdata;
    logic                  Pready;
    logic                  Pslverr;

    modport master (output Psel, Penable, Pwrite, Paddr, Pwdata, Pstrb,
                    input  Prdata, Pready, Pslverr);

    modport slave  (input  Psel, Penable, Pwrite, Paddr, Pwdata, Pstrb,
                    output Prdata, Pready, Pslverr);
endinterface

// File: rtl/apb_regfile_core.sv
// Register array for the APB slave: byte-strobe bus writes, hardware writes
// limited to read-only registers, and the flattened register image.
module apb_regfile_core
    import apb_slv_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           Pclk,
    input  logic                           Preset,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]    wr_idx,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [DATA_WIDTH/8-1:0]        wr_strb,
    input  logic                           hw_we,
    input  logic [$clog2(NUM_REGS)-1:0]    hw_idx,
    input  logic [DATA_WIDTH-1:0]          hw_wdata,
    input  logic [$clog2(NUM_REGS)-1:0]    rd_idx,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [31:0]           merged;
    logic                  hw_ok;
    logic                  apb_ok;

    assign merged  = strb_merge(32'(regs[wr_idx]), 32'(wr_data), 4'(wr_strb));
    assign hw_ok   = hw_we && (32'(hw_idx) < NUM_REGS) && RO_MASK[hw_idx];
    assign apb_ok  = wr_en && !RO_MASK[wr_idx];
    assign rd_data = regs[rd_idx];

    always_ff @(posedge Pclk) begin
        if (Preset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            if (apb_ok) begin
                regs[wr_idx] <= merged[DATA_WIDTH-1:0];
            end
            if (hw_ok) begin
                regs[hw_idx] <= hw_wdata;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

endmodule

// File: rtl/apb_regfile_slv.sv
// APB4 register-file slave: transfer FSM, wait counter, decode and error logic.
//  state | meaning
//  IDLE  | waiting for a setup phase
//  WAIT  | access phase, Pready held low while cnt runs down
//  RESP  | Pready high for one cycle; writes commit on leaving
module apb_regfile_slv
    import apb_slv_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           Pclk,
    input  logic                           Preset,
    apb_regfile_slv_if.slave               apb,
    input  logic                           hw_we,
    input  logic [$clog2(NUM_REGS)-1:0]    hw_idx,
    input  logic [DATA_WIDTH-1:0]          hw_wdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = $clog2(NUM_REGS);

    apb_slv_state_e          state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    pready_q, pready_d, pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d, rdat_q, rdat_d, wdata_q, wdata_d;
    logic [IDX_W-1:0]        idx_q, idx_d, idx_in;
    logic [NB-1:0]           strb_q, strb_d;
    logic                    write_q, write_d, err_q, err_d;
    logic [ADDR_WIDTH-LSB-1:0] word_idx;
    logic                    idx_ok, misalign, setup_err, setup, wr_en;
    logic [DATA_WIDTH-1:0]   rd_data;

    assign word_idx  = apb.Paddr[ADDR_WIDTH-1:LSB];
    assign idx_in    = word_idx[IDX_W-1:0];
    assign idx_ok    = 32'(word_idx) < NUM_REGS;
    assign misalign  = (apb.Paddr & ADDR_WIDTH'(NB - 1)) != '0;
    assign setup_err = !idx_ok || misalign || (apb.Pwrite && RO_MASK[idx_in]);
    assign setup     = apb.Psel && !apb.Penable;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        rdat_d    = rdat_q;
        wdata_d   = wdata_q;
        idx_d     = idx_q;
        strb_d    = strb_q;
        write_d   = write_q;
        err_d     = err_q;
        wr_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    idx_d   = idx_in;
                    write_d = apb.Pwrite;
                    wdata_d = apb.Pwdata;
                    strb_d  = apb.Pstrb;
                    err_d   = setup_err;
                    rdat_d  = rd_data;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = setup_err ? APB_ERR : APB_OKAY;
                        prdata_d  = setup_err ? '0 : rd_data;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (!apb.Psel) begin
                    state_d  = IDLE;
                    pready_d = 1'b0;
                end else if (cnt_q == 4'd0) begin
                    state_d   = RESP;
                    pready_d  = 1'b1;
                    pslverr_d = err_q ? APB_ERR : APB_OKAY;
                    prdata_d  = err_q ? '0 : rdat_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Psel dropped during the response aborts the write.
                wr_en     = apb.Psel && write_q && !err_q;
                state_d   = IDLE;
                pready_d  = 1'b0;
                pslverr_d = APB_OKAY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            rdat_q    <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            strb_q    <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            rdat_q    <= rdat_d;
            wdata_q   <= wdata_d;
            idx_q     <= idx_d;
            strb_q    <= strb_d;
            write_q   <= write_d;
            err_q     <= err_d;
        end
    end

    assign apb.Pready  = pready_q;
    assign apb.Pslverr = pslverr_q;
    assign apb.Prdata  = prdata_q;

    apb_regfile_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK),
        .RESET_VAL  (RESET_VAL)
    ) u_core (
        .Pclk     (Pclk),
        .Preset   (Preset),
        .wr_en    (wr_en),
        .wr_idx   (idx_q),
        .wr_data  (wdata_q),
        .wr_strb  (strb_q),
        .hw_we    (hw_we),
        .hw_idx   (hw_idx),
        .hw_wdata (hw_wdata),
        .rd_idx   (idx_in),
        .rd_data  (rd_data),
        .reg_q    (reg_q)
    );

endmodule

// File: tb/tb_apb_regfile_slv.sv
// Bench for apb_regfile_slv: three instances (0, 3 and 4 wait states) driven from
// shared bus signals with per-instance Psel, checked against an array model.
module tb_apb_regfile_slv;

    localparam int          NR = 16;
    localparam logic [31:0] RV = 32'h1357_9BDF;

    logic              Pclk = 1'b0;
    logic              Preset = 1'b1;
    logic [2:0]        psel_v = '0;
    logic              penable = 1'b0;
    logic              pwrite = 1'b0;
    logic [15:0]       paddr = '0;
    logic [31:0]       pwdata = '0;
    logic [3:0]        pstrb = '0;
    logic              hw_we = 1'b0;
    logic [3:0]        hw_idx = '0;
    logic [31:0]       hw_wdata = '0;

    logic [31:0]       prdata_a [3];
    logic              pready_a [3];
    logic              pslverr_a [3];
    logic [NR*32-1:0]  regq_a [3];

    logic [31:0]       mdl [3][NR];
    int                n_vec = 0;
    int                n_bad = 0;

    always #5 Pclk = ~Pclk;

    apb_regfile_slv_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].Psel    = psel_v[g];
        assign bus[g].Penable = penable;
        assign bus[g].Pwrite  = pwrite;
        assign bus[g].Paddr   = paddr;
        assign bus[g].Pwdata  = pwdata;
        assign bus[g].Pstrb   = pstrb;
        assign prdata_a[g]    = bus[g].Prdata;
        assign pready_a[g]    = bus[g].Pready;
        assign pslverr_a[g]   = bus[g].Pslverr;

        apb_regfile_slv #(
            .ADDR_WIDTH  (16),
            .DATA_WIDTH  (32),
            .NUM_REGS    (NR),
            .WAIT_CYCLES (g == 0 ? 0 : g + 2),
            .RO_MASK     (g == 0 ? 16'h0000 : 16'h0002),
            .RESET_VAL   (RV)
        ) u_dut (
            .Pclk     (Pclk),
            .Preset   (Preset),
            .apb      (bus[g]),
            .hw_we    (hw_we),
            .hw_idx   (hw_idx),
            .hw_wdata (hw_wdata),
            .reg_q    (regq_a[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic int wc_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 4;
    endfunction

    function automatic logic [15:0] ro_of(input int d);
        return (d == 0) ? 16'h0000 : 16'h0002;
    endfunction

    function automatic logic exp_err(input int d, input logic wr, input logic [15:0] a);
        int          idx;
        logic [15:0] ro;
        idx = int'(a) / 4;
        ro  = ro_of(d);
        if (int'(a) % 4 != 0) return 1'b1;
        if (idx >= NR) return 1'b1;
        return wr & ro[idx];
    endfunction

    function automatic logic [NR*32-1:0] flat(input int d);
        logic [NR*32-1:0] f;
        for (int i = 0; i < NR; i++) f[i*32 +: 32] = mdl[d][i];
        return f;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < NR; i++) mdl[d][i] = RV;
    endtask

    task automatic m_write(input int d, input int idx, input logic [31:0] wd, input logic [3:0] st);
        for (int b = 0; b < 4; b++)
            if (st[b]) mdl[d][idx][b*8 +: 8] = wd[b*8 +: 8];
    endtask

    task automatic m_hw(input int idx, input logic [31:0] data);
        logic [15:0] ro;
        for (int d = 0; d < 3; d++) begin
            ro = ro_of(d);
            if (ro[idx]) mdl[d][idx] = data;
        end
    endtask

    // ---------------- bus drivers ----------------
    task automatic xfer(input int d, input logic wr, input logic [15:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic hw_now, input logic [3:0] hwi,
                        input logic [31:0] hwd, output logic [31:0] rd, output logic err,
                        output int waits);
        @(posedge Pclk); #1;
        psel_v = 3'b001 << d; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
        hw_we = hw_now; hw_idx = hwi; hw_wdata = hwd;
        @(posedge Pclk); #1;
        penable = 1'b1; hw_we = 1'b0;
        waits = 0; rd = 'x; err = 1'bx;
        for (int k = 0; k < 40; k++) begin
            @(negedge Pclk);
            if (pready_a[d] === 1'b1) begin
                rd = prdata_a[d]; err = pslverr_a[d];
                return;
            end
            waits++;
            @(posedge Pclk); #1;
        end
        n_vec++; n_bad++;
        $display("FAIL xfer_timeout dut%0d addr=%h: Pready still low after 40 cycles", d, a);
    endtask

    task automatic run(input int d, input logic wr, input logic [15:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic err,
                       output int waits, output logic [31:0] e_rd, output logic e_err);
        e_err = exp_err(d, wr, a);
        e_rd  = e_err ? 32'h0 : mdl[d][int'(a) / 4];
        xfer(d, wr, a, wd, st, 1'b0, 4'd0, 32'd0, rd, err, waits);
        if (wr && !e_err) m_write(d, int'(a) / 4, wd, st);
    endtask

    task automatic idle();
        @(posedge Pclk); #1;
        psel_v = '0; penable = 1'b0; hw_we = 1'b0;
        @(negedge Pclk);
    endtask

    task automatic hw_write(input logic [3:0] idx, input logic [31:0] data);
        @(posedge Pclk); #1;
        psel_v = '0; penable = 1'b0;
        hw_we = 1'b1; hw_idx = idx; hw_wdata = data;
        @(posedge Pclk); #1;
        hw_we = 1'b0;
        m_hw(int'(idx), data);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Preset = 1'b1;
        repeat (3) @(posedge Pclk);
        #1 Preset = 1'b0;
        model_reset();
        @(negedge Pclk);
        for (int d = 0; d < 3; d++) begin
            n_vec++; if (pready_a[d] !== 1'b0) begin n_bad++; $display("FAIL rst_pready dut%0d got=%b exp=0", d, pready_a[d]); end
            n_vec++; if (pslverr_a[d] !== 1'b0) begin n_bad++; $display("FAIL rst_pslverr dut%0d got=%b exp=0", d, pslverr_a[d]); end
            n_vec++; if (prdata_a[d] !== 32'h0) begin n_bad++; $display("FAIL rst_prdata dut%0d got=%h exp=0", d, prdata_a[d]); end
            n_vec++; if (regq_a[d] !== flat(d)) begin n_bad++; $display("FAIL rst_regs dut%0d got=%h exp=%h", d, regq_a[d], flat(d)); end
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd, e_rd; logic err, e_err; int w;
        run(0, 1'b1, 16'h0004, 32'hDEAD_BEEF, 4'hF, rd, err, w, e_rd, e_err);
        n_vec++; if (w != 0) begin n_bad++; $display("FAIL zw_wr_waits got=%0d exp=0", w); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL zw_wr_err got=%b exp=0", err); end
        run(0, 1'b0, 16'h0004, 32'h0, 4'h0, rd, err, w, e_rd, e_err);
        n_vec++; if (w != 0) begin n_bad++; $display("FAIL zw_rd_waits got=%0d exp=0", w); end
        n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL zw_rd_data got=%h exp=deadbeef", rd); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL zw_rd_err got=%b exp=0", err); end
        idle();
        n_vec++; if (regq_a[0] !== flat(0)) begin n_bad++; $display("FAIL zw_regs got=%h exp=%h", regq_a[0], flat(0)); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, e_rd; logic err, e_err; int w;
        run(1, 1'b0, 16'h0008, 32'h0, 4'h0, rd, err, w, e_rd, e_err);
        n_vec++; if (w != 3) begin n_bad++; $display("FAIL ws3_waits got=%0d exp=3", w); end
        n_vec++; if (rd !== RV) begin n_bad++; $display("FAIL ws3_data got=%h exp=%h", rd, RV); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL ws3_err got=%b exp=0", err); end
        run(2, 1'b0, 16'h0008, 32'h0, 4'h0, rd, err, w, e_rd, e_err);
        n_vec++; if (w != 4) begin n_bad++; $display("FAIL ws4_waits got=%0d exp=4", w); end
    endtask

    task automatic test_strobe();
        logic [31:0] rd, e_rd; logic err, e_err; int w;
        run(0, 1'b1, 16'h0008, 32'h1122_3344, 4'hF, rd, err, w, e_rd, e_err);
        run(0, 1'b1, 16'h0008, 32'hAABB_CCDD, 4'b0101, rd, err, w, e_rd, e_err);
        run(0, 1'b0, 16'h0008, 32'h0, 4'h0, rd, err, w, e_rd, e_err);
        n_vec++; if (rd !== 32'h11BB_33DD) begin n_bad++; $display("FAIL strb_data got=%h exp=11bb33dd", rd); end
        n_vec++; if (rd !== e_rd) begin n_bad++; $display("FAIL strb_model got=%h exp=%h", rd, e_rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, e_rd; logic err, e_err; int w;
        logic [NR*32-1:0] snap;
        logic [15:0] bad [3];
        bad[0] = 16'h0040; bad[1] = 16'h0006; bad[2] = 16'h0004;
        for (int i = 0; i < 3; i++) begin
            idle();
            snap = regq_a[1];
            run(1, 1'b1, bad[i], 32'hFFFF_FFFF, 4'hF, rd, err, w, e_rd, e_err);
            n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_wr_%h got=%b exp=1", bad[i], err); end
            idle();
            n_vec++; if (regq_a[1] !== snap) begin n_bad++; $display("FAIL err_regs_%h got=%h exp=%h", bad[i], regq_a[1], snap); end
        end
        run(1, 1'b0, 16'h0040, 32'h0, 4'h0, rd, err, w, e_rd, e_err);
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_rd_flag got=%b exp=1", err); end
        n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL err_rd_data got=%h exp=0", rd); end
    endtask

    task automatic test_hw_port();
        logic [31:0] rd, e_rd; logic err, e_err; int w;
        hw_write(4'd1, 32'h5A5A_5A5A);
        run(1, 1'b0, 16'h0004, 32'h0, 4'h0, rd, err, w, e_rd, e_err);
        n_vec++; if (rd !== 32'h5A5A_5A5A) begin n_bad++; $display("FAIL hw_ro_data got=%h exp=5a5a5a5a", rd); end
        hw_write(4'd0, 32'hFFFF_0000);
        run(1, 1'b0, 16'h0000, 32'h0, 4'h0, rd, err, w, e_rd, e_err);
        n_vec++; if (rd !== RV) begin n_bad++; $display("FAIL hw_rw_ignored got=%h exp=%h", rd, RV); end
        // hw write lands on the same edge as the read setup: read must see the old value
        xfer(1, 1'b0, 16'h0004, 32'h0, 4'h0, 1'b1, 4'd1, 32'h1234_5678, rd, err, w);
        m_hw(1, 32'h1234_5678);
        n_vec++; if (rd !== 32'h5A5A_5A5A) begin n_bad++; $display("FAIL hw_same_cycle got=%h exp=5a5a5a5a", rd); end
        run(1, 1'b0, 16'h0004, 32'h0, 4'h0, rd, err, w, e_rd, e_err);
        n_vec++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL hw_after got=%h exp=12345678", rd); end
        idle();
        for (int d = 0; d < 3; d++) begin
            n_vec++; if (regq_a[d] !== flat(d)) begin n_bad++; $display("FAIL hw_regs dut%0d got=%h exp=%h", d, regq_a[d], flat(d)); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, e_rd; logic err, e_err; int w;
        run(2, 1'b1, 16'h000C, 32'h0F0F_1234, 4'hF, rd, err, w, e_rd, e_err);
        @(posedge Pclk); #1;
        psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 16'h000C;
        pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
        @(posedge Pclk); #1;
        penable = 1'b1;
        repeat (2) begin
            @(negedge Pclk);
            n_vec++; if (pready_a[2] !== 1'b0) begin n_bad++; $display("FAIL abort_wait_pready got=%b exp=0", pready_a[2]); end
            @(posedge Pclk); #1;
        end
        psel_v = '0; penable = 1'b0;
        repeat (6) begin
            @(negedge Pclk);
            n_vec++; if (pready_a[2] !== 1'b0) begin n_bad++; $display("FAIL abort_idle_pready got=%b exp=0", pready_a[2]); end
        end
        n_vec++; if (regq_a[2] !== flat(2)) begin n_bad++; $display("FAIL abort_regs got=%h exp=%h", regq_a[2], flat(2)); end
        run(2, 1'b0, 16'h000C, 32'h0, 4'h0, rd, err, w, e_rd, e_err);
        n_vec++; if (w != 4) begin n_bad++; $display("FAIL abort_next_waits got=%0d exp=4", w); end
        n_vec++; if (rd !== 32'h0F0F_1234) begin n_bad++; $display("FAIL abort_next_data got=%h exp=0f0f1234", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, e_rd; logic err, e_err; int w;
        run(2, 1'b1, 16'h0014, 32'h7777_8888, 4'hF, rd, err, w, e_rd, e_err);
        @(posedge Pclk); #1;
        psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0014;
        pwdata = 32'h0101_0101; pstrb = 4'hF;
        @(posedge Pclk); #1;
        penable = 1'b1;
        @(posedge Pclk); #1;
        Preset = 1'b1;
        @(posedge Pclk); #1;
        psel_v = '0; penable = 1'b0;
        model_reset();
        @(negedge Pclk);
        n_vec++; if (pready_a[2] !== 1'b0) begin n_bad++; $display("FAIL rstmid_pready got=%b exp=0", pready_a[2]); end
        for (int d = 0; d < 3; d++) begin
            n_vec++; if (regq_a[d] !== flat(d)) begin n_bad++; $display("FAIL rstmid_regs dut%0d got=%h exp=%h", d, regq_a[d], flat(d)); end
        end
        @(posedge Pclk); #1 Preset = 1'b0;
        run(2, 1'b0, 16'h0014, 32'h0, 4'h0, rd, err, w, e_rd, e_err);
        n_vec++; if (rd !== RV) begin n_bad++; $display("FAIL rstmid_read got=%h exp=%h", rd, RV); end
    endtask

    task automatic test_penable_ignored();
        @(posedge Pclk); #1;
        psel_v = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 16'h0010;
        pwdata = 32'hBADB_AD00; pstrb = 4'hF;
        repeat (4) begin
            @(negedge Pclk);
            n_vec++; if (pready_a[0] !== 1'b0) begin n_bad++; $display("FAIL pen_only_pready got=%b exp=0", pready_a[0]); end
        end
        idle();
        idle();
        n_vec++; if (regq_a[0] !== flat(0)) begin n_bad++; $display("FAIL pen_only_regs got=%h exp=%h", regq_a[0], flat(0)); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, e_rd; logic err, e_err; int w;
        logic [31:0] wd;
        for (int i = 0; i < 8; i++) begin
            wd = $urandom;
            run(0, 1'b1, 16'(i * 4), wd, 4'($urandom_range(0, 15)), rd, err, w, e_rd, e_err);
        end
        for (int i = 0; i < 8; i++) begin
            run(0, 1'b0, 16'(i * 4), 32'h0, 4'h0, rd, err, w, e_rd, e_err);
            n_vec++; if (rd !== e_rd) begin n_bad++; $display("FAIL b2b_data idx%0d got=%h exp=%h", i, rd, e_rd); end
            n_vec++; if (w != 0) begin n_bad++; $display("FAIL b2b_waits idx%0d got=%0d exp=0", i, w); end
        end
        idle();
        n_vec++; if (pready_a[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_pready_drop got=%b exp=0", pready_a[0]); end
    endtask

    task automatic test_random();
        logic [31:0] rd, e_rd; logic err, e_err; int w;
        int d, r; logic wr; logic [15:0] a;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 5) == 0) hw_write(4'($urandom_range(0, 15)), $urandom);
            d  = $urandom_range(0, 2);
            wr = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            if (r < 8)       a = 16'($urandom_range(0, NR - 1) * 4);
            else if (r == 8) a = 16'($urandom_range(0, NR - 1) * 4 + $urandom_range(1, 3));
            else             a = 16'($urandom_range(NR, 63) * 4);
            run(d, wr, a, $urandom, 4'($urandom_range(0, 15)), rd, err, w, e_rd, e_err);
            n_vec++; if (err !== e_err) begin n_bad++; $display("FAIL rnd_err dut%0d a=%h wr=%b got=%b exp=%b", d, a, wr, err, e_err); end
            n_vec++; if (w != wc_of(d)) begin n_bad++; $display("FAIL rnd_waits dut%0d got=%0d exp=%0d", d, w, wc_of(d)); end
            if (!wr) begin
                n_vec++; if (rd !== e_rd) begin n_bad++; $display("FAIL rnd_data dut%0d a=%h got=%h exp=%h", d, a, rd, e_rd); end
            end
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (regq_a[k] !== flat(k)) begin n_bad++; $display("FAIL rnd_regs dut%0d got=%h exp=%h", k, regq_a[k], flat(k)); end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_strobe();
        test_errors();
        test_hw_port();
        test_abort();
        test_reset_mid();
        test_penable_ignored();
        test_back_to_back();
        test_random();
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
